alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single RV32 ALU between two requesters (requester 0: execute stage integer ops; requester 1: branch-compare / address-generation unit) using a round-robin, valid/ready protocol. It latches the winning request's operands and function code, drives the ALU from registers for one cycle, and captures the result and Z/N/C/V flags. The captured result is held until the owning requester accepts it. The block sits between the decode/issue logic and the combinational ALU in the execute stage.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- FOPW, 4, function-code width (fop_t)

Ports:
- clk  input  1  system clock, rising edge
- nRst  input  1  asynchronous, active-low reset
- req_valid  input  2  request valid, one bit per requester
- req_ready  output  2  request accepted this cycle (at most one bit high)
- req_rda0 / req_rda1  input  WIDTH  operand A per requester
- req_rdb0 / req_rdb1  input  WIDTH  operand B per requester
- req_fop0 / req_fop1  input  FOPW  function code per requester
- alu_rda, alu_rdb  output  WIDTH  registered operands to ALU
- alu_fop  output  FOPW  registered function code to ALU
- alu_result  input  WIDTH  ALU result (combinational)
- alu_flags  input  4  {Z,N,C,V} from ALU
- rsp_valid  output  2  response valid; only the owner's bit may be high
- rsp_ready  input  2  response accepted by requester
- rsp_result  output  WIDTH  captured result (shared bus)
- rsp_flags  output  4  captured {Z,N,C,V}
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**:
  - If any req_valid bit is set, grant one requester: the requester pointed to by rr_ptr if it is valid, otherwise the other valid requester.
  - req_ready[grant] is combinationally high this cycle only.
  - Latch rda/rdb/fop into alu_* registers, record owner = grant, and go to EXEC.
  - If no request is valid, stay in IDLE; req_ready = 0.
- **EXEC**:
  - The ALU evaluates the registered operands.
  - At the clock edge, capture alu_result → rsp_result and alu_flags → rsp_flags, set rsp_valid[owner], and go to RESP.
  - req_ready = 0.
- **RESP**:
  - Hold rsp_valid[owner], rsp_result and rsp_flags stable until rsp_ready[owner] = 1.
  - On the accepting edge: clear rsp_valid, set rr_ptr = ~owner, go to IDLE.
  - rsp_ready on the non-owner bit is ignored.
  - req_ready = 0.
- The ALU result and flags are passed through unmodified. Unknown fop values are forwarded as-is; the ALU returns 0, so Z = 1 is captured.
- Requesters must hold operands stable while req_valid is high and not yet readied. After req_ready, the block does not sample the requester's operands again.
- Reset values: state = IDLE, rr_ptr = 0, owner = 0, alu_rda = alu_rdb = 0, alu_fop = FOP_ADD, rsp_valid = 0, rsp_result = 0, rsp_flags = 0, busy = 0, req_ready = 0.
- Reset asserted mid-transaction (in EXEC or RESP): the transaction is dropped with no response. The requester re-issues, because its req_valid is still high.

## Timing
- Accept at edge N (req_ready high in cycle N).
- rsp_valid rises in cycle N+2.
- Minimum turnaround is 3 cycles per operation (IDLE → EXEC → RESP → IDLE), with no pipelining.
- Fairness: rr_ptr toggles only on a completed response. With both requesters continuously valid, grants alternate 0,1,0,1. Worst-case wait is one other transaction.
- Simultaneous valid requests in IDLE: exactly one req_ready, chosen by rr_ptr. The loser sees req_ready = 0 and must hold its request.
- Backpressure: while rsp_ready[owner] = 0, the FSM stays in RESP indefinitely, with outputs frozen and no new grant.
- rsp_valid and rsp_result are registered outputs; req_ready is a combinational function of state, rr_ptr and req_valid.

## Structure
- Shared package rv32_pkg contains:
  - fop_t (FOP_ADD = 0 … FOP_IMM = 8)
  - the flag-index constants FLAG_Z = 3, FLAG_N = 2, FLAG_C = 1, FLAG_V = 0
  - the arbiter state enum arb_state_t {IDLE, EXEC, RESP}
- One sub-module, rr_arb2: a combinational 2-way round-robin grant from (req_valid, rr_ptr) to a one-hot grant. The FSM, registers and muxes live in alu_arbiter.
- The ALU is instantiated by the parent and connected to the alu_* ports; it is not instantiated inside this block.

## Test plan
- Req0 only, FOP_ADD, 14 + 2 → req_ready[0] in cycle 0, rsp_valid[0] in cycle 2, rsp_result = 16, rsp_flags = 0000.
- Both valid right after reset: req0 FOP_SUB 68 − 29 and req1 FOP_SLL 7 << 2.
  - Req0 is granted first → 39.
  - After its response, req1 is granted → 28.
  - req_ready is never high on both bits.
- Both held valid for 4 transactions → grant order 0,1,0,1. busy stays high except for a single IDLE cycle between transactions.
- Req1 FOP_XOR with equal operands, rsp_ready[1] low for 5 cycles:
  - rsp_result = 0 and Z = 1 are held stable.
  - rsp_valid[1] stays high.
  - No req_ready is asserted despite req0 being valid.
  - The response completes on the cycle rsp_ready[1] rises.
- nRst pulsed low during EXEC of req0 → rsp_valid = 0, busy = 0, rr_ptr = 0. After release, the still-valid req0 is re-accepted and completes normally.
- Req0 with unknown fop = 4'hF → rsp_result = 0, Z = 1; the FSM returns to IDLE normally.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage types: ALU function codes, flag bit positions
// and the ALU arbiter state encoding.
package rv32_pkg;

  localparam int unsigned FOP_W  = 4;
  localparam int unsigned FLAG_W = 4;

  // ALU function codes; values 9..15 are unassigned and make the ALU return 0
  typedef enum logic [FOP_W-1:0] {
    FOP_ADD = 4'd0,
    FOP_SUB = 4'd1,
    FOP_AND = 4'd2,
    FOP_OR  = 4'd3,
    FOP_XOR = 4'd4,
    FOP_SLL = 4'd5,
    FOP_SRL = 4'd6,
    FOP_SRA = 4'd7,
    FOP_IMM = 4'd8
  } fop_t;

  // Bit positions inside the {Z,N,C,V} flag vector
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
//   req_valid : request bits from requesters 0 and 1
//   rr_ptr    : preferred requester when both are valid
//   grant_c   : one-hot grant (all zero when nothing is valid)
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       rr_ptr,
  output logic [1:0] grant_c
);

  // The pointed-to requester wins if valid; otherwise the other one may take it
  always_comb begin
    grant_c = 2'b00;
    if (rr_ptr == 1'b0) begin
      grant_c[0] = req_valid[0];
      grant_c[1] = req_valid[1] & ~req_valid[0];
    end else begin
      grant_c[1] = req_valid[1];
      grant_c[0] = req_valid[0] & ~req_valid[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational RV32 ALU between two requesters (0: execute-stage
// integer ops, 1: branch-compare / address generation). One operation in
// flight: IDLE grants and latches operands, EXEC lets the ALU evaluate the
// registered operands and captures result/flags, RESP holds the response
// until the owning requester accepts it.
//   req_*      : valid/ready request side, operands and fop per requester
//   alu_*      : registered operands to the ALU, result/flags back from it
//   rsp_*      : valid/ready response side, shared result/flags bus
//   busy       : high whenever the FSM is not in IDLE
module alu_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FOPW  = 4
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_rda0,
  input  logic [WIDTH-1:0] req_rda1,
  input  logic [WIDTH-1:0] req_rdb0,
  input  logic [WIDTH-1:0] req_rdb1,
  input  logic [FOPW-1:0]  req_fop0,
  input  logic [FOPW-1:0]  req_fop1,
  output logic [WIDTH-1:0] alu_rda,
  output logic [WIDTH-1:0] alu_rdb,
  output logic [FOPW-1:0]  alu_fop,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             busy
);

  arb_state_t       state, state_nxt;
  logic             rr_ptr, rr_ptr_nxt;
  logic             owner, owner_nxt;
  logic [WIDTH-1:0] alu_rda_nxt, alu_rdb_nxt;
  logic [FOPW-1:0]  alu_fop_nxt;
  logic [1:0]       rsp_valid_nxt;
  logic [WIDTH-1:0] rsp_result_nxt;
  logic [3:0]       rsp_flags_nxt;
  logic             busy_nxt;
  logic [1:0]       grant_c;

  rr_arb2 u_rr_arb2 (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_c   (grant_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      alu_rda    <= '0;
      alu_rdb    <= '0;
      alu_fop    <= FOPW'(FOP_ADD);
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_flags  <= 4'b0000;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      owner      <= owner_nxt;
      alu_rda    <= alu_rda_nxt;
      alu_rdb    <= alu_rdb_nxt;
      alu_fop    <= alu_fop_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_result <= rsp_result_nxt;
      rsp_flags  <= rsp_flags_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state logic; req_ready is the only combinational output
  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    owner_nxt      = owner;
    alu_rda_nxt    = alu_rda;
    alu_rdb_nxt    = alu_rdb;
    alu_fop_nxt    = alu_fop;
    rsp_valid_nxt  = rsp_valid;
    rsp_result_nxt = rsp_result;
    rsp_flags_nxt  = rsp_flags;
    busy_nxt       = busy;
    req_ready      = 2'b00;

    case (state)
      IDLE: begin
        if (grant_c != 2'b00) begin
          req_ready   = grant_c;
          owner_nxt   = grant_c[1];
          alu_rda_nxt = grant_c[1] ? req_rda1 : req_rda0;
          alu_rdb_nxt = grant_c[1] ? req_rdb1 : req_rdb0;
          alu_fop_nxt = grant_c[1] ? req_fop1 : req_fop0;
          busy_nxt    = 1'b1;
          state_nxt   = EXEC;
        end
      end
      EXEC: begin
        rsp_result_nxt = alu_result;
        rsp_flags_nxt  = alu_flags;
        rsp_valid_nxt  = {owner, ~owner};
        state_nxt      = RESP;
      end
      RESP: begin
        // Only the owner's ready bit can retire the response
        if (rsp_ready[owner]) begin
          rsp_valid_nxt = 2'b00;
          rr_ptr_nxt    = ~owner;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        rsp_valid_nxt = 2'b00;
        busy_nxt      = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural RV32 ALU hooked to the
// alu_* ports. Inputs change and outputs are sampled around the falling edge.
module tb_alu_arbiter;
  import rv32_pkg::*;

  logic        clk;
  logic        nRst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_rda0, req_rda1, req_rdb0, req_rdb1;
  logic [3:0]  req_fop0, req_fop1;
  logic [31:0] alu_rda, alu_rdb;
  logic [3:0]  alu_fop;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        busy;

  int n_checks;
  int n_fail;

  alu_arbiter #(.WIDTH(32), .FOPW(4)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rda0   (req_rda0),
    .req_rda1   (req_rda1),
    .req_rdb0   (req_rdb0),
    .req_rdb1   (req_rdb1),
    .req_fop0   (req_fop0),
    .req_fop1   (req_fop1),
    .alu_rda    (alu_rda),
    .alu_rdb    (alu_rdb),
    .alu_fop    (alu_fop),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU returning {Z,N,C,V,result}
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (f)
      4'(FOP_ADD): begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'(FOP_SUB): begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'(FOP_AND): r = a & b;
      4'(FOP_OR):  r = a | b;
      4'(FOP_XOR): r = a ^ b;
      4'(FOP_SLL): r = a << b[4:0];
      4'(FOP_SRL): r = a >> b[4:0];
      4'(FOP_SRA): r = 32'($signed(a) >>> b[4:0]);
      4'(FOP_IMM): r = b;
      default:     r = '0;
    endcase
    return {(r == 32'd0), r[31], c, v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_rda, alu_rdb, alu_fop);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    nRst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_rda0 = '0; req_rdb0 = '0; req_fop0 = '0;
    req_rda1 = '0; req_rdb1 = '0; req_fop1 = '0;
    @(negedge clk); #1;
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if ({alu_rda, alu_rdb} !== 64'd0) begin n_fail++; $display("FAIL reset_alu_ops: got %h/%h want 0/0", alu_rda, alu_rdb); end
    n_checks++;
    if (alu_fop !== 4'd0) begin n_fail++; $display("FAIL reset_alu_fop: got %h want 0", alu_fop); end
    n_checks++;
    if ({rsp_result, rsp_flags} !== 36'd0) begin n_fail++; $display("FAIL reset_rsp: got %h/%b want 0/0000", rsp_result, rsp_flags); end
    @(negedge clk);
    nRst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    @(negedge clk);
    req_rda0 = 32'd14; req_rdb0 = 32'd2; req_fop0 = 4'(FOP_ADD);
    req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    n_checks++;
    if ({rsp_valid, busy} !== 3'b001) begin n_fail++; $display("FAIL single_exec: rsp_valid/busy got %b/%b want 00/1", rsp_valid, busy); end
    n_checks++;
    if ({alu_rda, alu_rdb, alu_fop} !== {32'd14, 32'd2, 4'd0}) begin
      n_fail++; $display("FAIL single_alu_regs: got %0d/%0d/%h want 14/2/0", alu_rda, alu_rdb, alu_fop);
    end
    @(negedge clk); #1;
    n_checks++;
    if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
    n_checks++;
    if (rsp_result !== 32'd16) begin n_fail++; $display("FAIL single_result: got %0d want 16", rsp_result); end
    n_checks++;
    if (rsp_flags !== 4'b0000) begin n_fail++; $display("FAIL single_flags: got %b want 0000", rsp_flags); end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    n_checks++;
    if ({rsp_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL single_done: rsp_valid/busy got %b/%b want 00/0", rsp_valid, busy); end
  endtask

  task automatic test_both();
    do_reset();
    req_rda0 = 32'd68; req_rdb0 = 32'd29; req_fop0 = 4'(FOP_SUB);
    req_rda1 = 32'd7;  req_rdb1 = 32'd2;  req_fop1 = 4'(FOP_SLL);
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL both_first_grant: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL both_exec_ready: got %b want 00", req_ready); end
    @(negedge clk); #1;
    n_checks++;
    if ({rsp_valid, rsp_result} !== {2'b01, 32'd39}) begin
      n_fail++; $display("FAIL both_rsp0: got %b/%0d want 01/39", rsp_valid, rsp_result);
    end
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL both_resp_ready: got %b want 00", req_ready); end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid} !== 4'b1000) begin
      n_fail++; $display("FAIL both_second_grant: req_ready/rsp_valid got %b/%b want 10/00", req_ready, rsp_valid);
    end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    n_checks++;
    if ({alu_rda, alu_fop} !== {32'd7, 4'(FOP_SLL)}) begin
      n_fail++; $display("FAIL both_alu_regs1: got %0d/%h want 7/5", alu_rda, alu_fop);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({rsp_valid, rsp_result} !== {2'b10, 32'd28}) begin
      n_fail++; $display("FAIL both_rsp1: got %b/%0d want 10/28", rsp_valid, rsp_result);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    n_checks++;
    if ({rsp_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL both_done: rsp_valid/busy got %b/%b want 00/0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_grant;
    logic [31:0] exp_res;
    do_reset();
    req_rda0 = 32'd1; req_rdb0 = 32'd1; req_fop0 = 4'(FOP_ADD);
    req_rda1 = 32'd5; req_rdb1 = 32'd5; req_fop1 = 4'(FOP_ADD);
    req_valid = 2'b11;
    #1;
    for (int t = 0; t < 4; t++) begin
      exp_grant = (t % 2 == 1) ? 2'b10 : 2'b01;
      exp_res   = (t % 2 == 1) ? 32'd10 : 32'd2;
      n_checks++;
      if ({req_ready, busy} !== {exp_grant, 1'b0}) begin
        n_fail++; $display("FAIL rr_grant_%0d: req_ready/busy got %b/%b want %b/0", t, req_ready, busy, exp_grant);
      end
      @(negedge clk); #1;
      n_checks++;
      if ({req_ready, busy} !== 3'b001) begin
        n_fail++; $display("FAIL rr_exec_%0d: req_ready/busy got %b/%b want 00/1", t, req_ready, busy);
      end
      @(negedge clk); #1;
      n_checks++;
      if ({rsp_valid, rsp_result, busy} !== {exp_grant, exp_res, 1'b1}) begin
        n_fail++; $display("FAIL rr_rsp_%0d: got %b/%0d/%b want %b/%0d/1", t, rsp_valid, rsp_result, busy, exp_grant, exp_res);
      end
      rsp_ready = 2'b11;
      @(negedge clk);
      rsp_ready = 2'b00;
      #1;
    end
    req_valid = 2'b00;
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_rda1 = 32'h5A5A_5A5A; req_rdb1 = 32'h5A5A_5A5A; req_fop1 = 4'(FOP_XOR);
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_grant1: got %b want 10", req_ready); end
    @(negedge clk);
    req_rda0 = 32'd9; req_rdb0 = 32'd1; req_fop0 = 4'(FOP_ADD);
    req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_exec_ready: got %b want 00", req_ready); end
    @(negedge clk);
    rsp_ready = 2'b01;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_flags, req_ready, busy} !== {2'b10, 32'd0, 4'b1000, 2'b00, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: valid/result/flags/ready/busy got %b/%h/%b/%b/%b want 10/0/1000/00/1",
                 i, rsp_valid, rsp_result, rsp_flags, req_ready, busy);
      end
      @(negedge clk); #1;
    end
    rsp_ready = 2'b10;
    #1;
    n_checks++;
    if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL bp_last_hold: got %b want 10", rsp_valid); end
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    n_checks++;
    if ({rsp_valid, req_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL bp_release: rsp_valid/req_ready got %b/%b want 00/01", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    n_checks++;
    if ({rsp_valid, rsp_result} !== {2'b01, 32'd10}) begin
      n_fail++; $display("FAIL bp_rsp0: got %b/%0d want 01/10", rsp_valid, rsp_result);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_rda0 = 32'd3; req_rdb0 = 32'd4; req_fop0 = 4'(FOP_ADD);
    req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_grant: got %b want 01", req_ready); end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_exec_busy: got %b want 1", busy); end
    nRst = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, busy, dut.rr_ptr} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_drop: rsp_valid/busy/rr_ptr got %b/%b/%b want 00/0/0", rsp_valid, busy, dut.rr_ptr);
    end
    @(negedge clk);
    nRst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_reaccept: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_flags} !== {2'b01, 32'd7, 4'b0000}) begin
      n_fail++; $display("FAIL rstmid_rsp: got %b/%0d/%b want 01/7/0000", rsp_valid, rsp_result, rsp_flags);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_unknown_fop();
    @(negedge clk);
    req_rda0 = 32'd123; req_rdb0 = 32'd456; req_fop0 = 4'hF;
    req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL unk_grant: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    n_checks++;
    if (alu_fop !== 4'hF) begin n_fail++; $display("FAIL unk_alu_fop: got %h want f", alu_fop); end
    @(negedge clk); #1;
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_flags} !== {2'b01, 32'd0, 4'b1000}) begin
      n_fail++; $display("FAIL unk_rsp: got %b/%h/%b want 01/0/1000", rsp_valid, rsp_result, rsp_flags);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    n_checks++;
    if ({rsp_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL unk_done: rsp_valid/busy got %b/%b want 00/0", rsp_valid, busy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_both();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_unknown_fop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
